// File: rtl/node_sched_pkg.sv
// Shared types and constants for the node_mac_sched layer scheduler.
// Configuration macro: NODE_RELU_EN selects a ReLU on each node result.
package node_sched_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

  typedef enum logic [2:0] {IDLE, LOAD_B, MAC, OUT, DONE} state_t;

  // Which read addresses the address generator presents this cycle.
  typedef enum logic [2:0] {
    AOP_NONE,      // both addresses 0
    AOP_BIAS0,     // bias of node 0 (start accept)
    AOP_FIRST,     // input 0 of current node
    AOP_NEXT_ELEM, // input idx+1 of current node
    AOP_NEXT_BIAS  // bias of node+1
  } aop_t;

  // Output activation applied to a finished accumulator.
  function automatic logic [FP_W-1:0] node_act(input logic [FP_W-1:0] a);
`ifdef NODE_RELU_EN
    // Sign bit set covers -0.0 too, so every negative becomes +0.0.
    return a[FP_W-1] ? FP_ZERO : a;
`else
    return a;
`endif
  endfunction

endpackage

// File: rtl/node_sched_addrgen.sv
// Node/input counters and synchronous-memory read address generation.
// Addresses are combinational so the memory returns data the next cycle.
module node_sched_addrgen
  import node_sched_pkg::*;
#(
  parameter int N_IN    = 15,
  parameter int N_NODE  = 8,
  parameter int WADDR_W = 7,
  parameter int AADDR_W = 4,
  parameter int NADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv_node,
  input  logic               adv_idx,
  input  aop_t               aop,
  output logic [NADDR_W-1:0] node,
  output logic               last_idx,
  output logic               last_node,
  output logic [WADDR_W-1:0] w_addr,
  output logic [AADDR_W-1:0] act_addr
);

  localparam logic [WADDR_W-1:0] STRIDE = WADDR_W'(N_IN + 1);

  logic [AADDR_W-1:0] idx;
  logic [WADDR_W-1:0] base;

  assign base      = WADDR_W'(node) * STRIDE;
  assign last_idx  = (idx == AADDR_W'(N_IN - 1));
  assign last_node = (node == NADDR_W'(N_NODE - 1));

  // Node counter advances per handshake; input index restarts with each node.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node <= '0;
      idx  <= '0;
    end else if (clr) begin
      node <= '0;
      idx  <= '0;
    end else if (adv_node) begin
      node <= node + NADDR_W'(1);
      idx  <= '0;
    end else if (adv_idx) begin
      idx <= idx + AADDR_W'(1);
    end
  end

  // Address mux: bias sits after the node's N_IN weights.
  always_comb begin
    w_addr   = '0;
    act_addr = '0;
    unique case (aop)
      AOP_BIAS0:     w_addr = WADDR_W'(N_IN);
      AOP_FIRST:     w_addr = base;
      AOP_NEXT_ELEM: begin
        w_addr   = base + WADDR_W'(idx) + WADDR_W'(1);
        act_addr = idx + AADDR_W'(1);
      end
      AOP_NEXT_BIAS: w_addr = base + STRIDE + WADDR_W'(N_IN);
      default: ;
    endcase
  end

endmodule

// File: rtl/node_mac_sched.sv
// Time-multiplexed MAC scheduler for one fully-connected layer: one shared
// float_mult/float_adder pair walks bias then inputs 0..N_IN-1 per node.
// Configuration macro: NODE_RELU_EN (ReLU on out_data when defined).
module node_mac_sched
  import node_sched_pkg::*;
#(
  parameter int N_IN    = 15,
  parameter int N_NODE  = 8,
  parameter int WADDR_W = $clog2(N_NODE * (N_IN + 1)),
  parameter int AADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int NADDR_W = (N_NODE > 1) ? $clog2(N_NODE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [AADDR_W-1:0] act_addr,
  input  logic [FP_W-1:0]    act_data,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [FP_W-1:0]    w_data,
  output logic [FP_W-1:0]    mul_x,
  output logic [FP_W-1:0]    mul_y,
  input  logic [FP_W-1:0]    mul_z,
  output logic [FP_W-1:0]    add_a,
  output logic [FP_W-1:0]    add_b,
  input  logic [FP_W-1:0]    add_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NADDR_W-1:0] out_idx,
  output logic [FP_W-1:0]    out_data
);

  state_t             state, state_n;
  aop_t               aop;
  logic               clr, adv_node, adv_idx, ld_bias, ld_sum;
  logic               last_idx, last_node;
  logic [NADDR_W-1:0] node;
  logic [FP_W-1:0]    acc;

  node_sched_addrgen #(
    .N_IN(N_IN), .N_NODE(N_NODE),
    .WADDR_W(WADDR_W), .AADDR_W(AADDR_W), .NADDR_W(NADDR_W)
  ) u_addrgen (
    .clk(clk), .rst(rst), .clr(clr), .adv_node(adv_node), .adv_idx(adv_idx),
    .aop(aop), .node(node), .last_idx(last_idx), .last_node(last_node),
    .w_addr(w_addr), .act_addr(act_addr)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, counter controls and address requests.
  always_comb begin
    state_n  = state;
    aop      = AOP_NONE;
    clr      = 1'b0;
    adv_node = 1'b0;
    adv_idx  = 1'b0;
    ld_bias  = 1'b0;
    ld_sum   = 1'b0;
    unique case (state)
      IDLE: if (start && !rst) begin
        clr     = 1'b1;
        aop     = AOP_BIAS0;
        state_n = LOAD_B;
      end
      LOAD_B: begin
        ld_bias = 1'b1;
        aop     = AOP_FIRST;
        state_n = MAC;
      end
      MAC: begin
        ld_sum = 1'b1;
        if (!last_idx) begin
          adv_idx = 1'b1;
          aop     = AOP_NEXT_ELEM;
        end else begin
          state_n = OUT;
        end
      end
      OUT: if (out_ready) begin
        if (last_node) begin
          state_n = DONE;
        end else begin
          adv_node = 1'b1;
          aop      = AOP_NEXT_BIAS;
          state_n  = LOAD_B;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Accumulator: seeded with the bias, then one product added per MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          acc <= FP_ZERO;
    else if (ld_bias) acc <= w_data;
    else if (ld_sum)  acc <= add_out;
  end

  // Operands only toggle during MAC; results only shown in OUT.
  always_comb begin
    mul_x     = (state == MAC) ? act_data : FP_ZERO;
    mul_y     = (state == MAC) ? w_data   : FP_ZERO;
    add_a     = (state == MAC) ? acc      : FP_ZERO;
    add_b     = (state == MAC) ? mul_z    : FP_ZERO;
    busy      = (state != IDLE);
    done      = (state == DONE);
    out_valid = (state == OUT);
    out_idx   = (state == OUT) ? node : '0;
    out_data  = (state == OUT) ? node_act(acc) : FP_ZERO;
  end

endmodule

// File: tb/tb_node_mac_sched.sv
// Self-checking bench for node_mac_sched: a small (2x2) instance for the
// directed float scenarios and a default-size instance for the reset case.
module tb_node_mac_sched;

  localparam int SN = 2, SM = 2, SWA = 3, SAA = 1, SNA = 1;
  localparam int DN = 15, DM = 8, DWA = 7, DAA = 4, DNA = 3;

  typedef struct { int idx; logic [31:0] data; int cyc; } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   t0  = 0;
  int   vectors = 0, miscompares = 0;
  exp_t sq_s[$], sq_d[$];

  // small instance signals
  logic rst_s, start_s, busy_s, done_s, out_valid_s, out_ready_s;
  logic [SAA-1:0] act_addr_s;  logic [SWA-1:0] w_addr_s;  logic [SNA-1:0] out_idx_s;
  logic [31:0] act_data_s, w_data_s, mul_x_s, mul_y_s, mul_z_s, add_a_s, add_b_s, add_out_s, out_data_s;
  logic [31:0] amem_s[0:1], wmem_s[0:7];
  // default instance signals
  logic rst_d, start_d, busy_d, done_d, out_valid_d, out_ready_d;
  logic [DAA-1:0] act_addr_d;  logic [DWA-1:0] w_addr_d;  logic [DNA-1:0] out_idx_d;
  logic [31:0] act_data_d, w_data_d, mul_x_d, mul_y_d, mul_z_d, add_a_d, add_b_d, add_out_d, out_data_d;
  logic [31:0] amem_d[0:15], wmem_d[0:127];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  node_mac_sched #(.N_IN(SN), .N_NODE(SM)) u_small (
    .clk(clk), .rst(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
    .act_addr(act_addr_s), .act_data(act_data_s), .w_addr(w_addr_s), .w_data(w_data_s),
    .mul_x(mul_x_s), .mul_y(mul_y_s), .mul_z(mul_z_s), .add_a(add_a_s), .add_b(add_b_s),
    .add_out(add_out_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_idx(out_idx_s), .out_data(out_data_s));

  node_mac_sched u_dflt (
    .clk(clk), .rst(rst_d), .start(start_d), .busy(busy_d), .done(done_d),
    .act_addr(act_addr_d), .act_data(act_data_d), .w_addr(w_addr_d), .w_data(w_data_d),
    .mul_x(mul_x_d), .mul_y(mul_y_d), .mul_z(mul_z_d), .add_a(add_a_d), .add_b(add_b_d),
    .add_out(add_out_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
    .out_idx(out_idx_d), .out_data(out_data_d));

  // single <-> double conversion for normal values and zeros
  function automatic real s2r(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'd0) return $bitstoreal({s[31], 63'd0});
    e = {3'b000, s[30:23]} + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] i2f(input int v);
    return r2s(real'(v));
  endfunction

  function automatic logic [31:0] act_f(input int v);
`ifdef NODE_RELU_EN
    return (v < 0) ? 32'd0 : i2f(v);
`else
    return i2f(v);
`endif
  endfunction

  // float_mult / float_adder models and synchronous memories
  always_comb begin
    mul_z_s   = r2s(s2r(mul_x_s) * s2r(mul_y_s));
    add_out_s = r2s(s2r(add_a_s) + s2r(add_b_s));
    mul_z_d   = r2s(s2r(mul_x_d) * s2r(mul_y_d));
    add_out_d = r2s(s2r(add_a_d) + s2r(add_b_d));
  end

  always @(posedge clk) begin
    act_data_s <= amem_s[act_addr_s];
    w_data_s   <= wmem_s[w_addr_s];
    act_data_d <= amem_d[act_addr_d];
    w_data_d   <= wmem_d[w_addr_d];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input bit dflt, input int idx, input logic [31:0] data);
    exp_t e;
    if ((dflt ? sq_d.size() : sq_s.size()) == 0) begin
      chk(dflt ? "unexp_out_d" : "unexp_out_s", 64'(idx), 64'hFFFF);
      return;
    end
    e = dflt ? sq_d.pop_front() : sq_s.pop_front();
    chk(dflt ? "out_idx_d"  : "out_idx_s",  64'(idx), 64'(e.idx));
    chk(dflt ? "out_data_d" : "out_data_s", 64'(data), 64'(e.data));
    chk(dflt ? "out_cyc_d"  : "out_cyc_s",  64'(cyc - t0), 64'(e.cyc));
  endtask

  // Output monitor, sampled mid-low-phase after inputs driven at negedge settle.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  int          prev_idx;
  always @(negedge clk) begin
    #2;
    if (prev_hold) begin
      chk("hold_idx", 64'(out_idx_s), 64'(prev_idx));
      chk("hold_data", 64'(out_data_s), 64'(prev_data));
    end
    prev_hold = out_valid_s && !out_ready_s;
    prev_idx  = int'(out_idx_s);
    prev_data = out_data_s;
    if (out_valid_s && out_ready_s) check_out(1'b0, int'(out_idx_s), out_data_s);
    if (out_valid_d && out_ready_d) check_out(1'b1, int'(out_idx_d), out_data_d);
  end

  task automatic start_pulse(input bit dflt);
    @(negedge clk);
    if (dflt) start_d = 1'b1; else start_s = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_s = 1'b0;
    start_d = 1'b0;
  endtask

  task automatic wait_done(input bit dflt, input int exp_c);
    int c = -1;
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (dflt ? done_d : done_s) begin
        seen = 1'b1;
        c = cyc - t0;
        chk("busy_at_done", 64'(dflt ? busy_d : busy_s), 64'd1);
      end
    end
    chk(dflt ? "done_cyc_d" : "done_cyc_s", 64'(c), 64'(exp_c));
    @(negedge clk);
    chk("busy_after_done", 64'(dflt ? busy_d : busy_s), 64'd0);
    chk("sb_empty", 64'(dflt ? sq_d.size() : sq_s.size()), 64'd0);
  endtask

  function automatic exp_t mk(input int idx, input logic [31:0] d, input int c);
    exp_t e;
    e.idx = idx; e.data = d; e.cyc = c;
    return e;
  endfunction

  initial begin
    logic [31:0] n1;
    int s, w;
`ifdef NODE_RELU_EN
    n1 = 32'h00000000;
`else
    n1 = 32'hC0200000;
`endif
    amem_s[0] = 32'h3F800000; amem_s[1] = 32'h40000000;
    for (int i = 0; i < 8; i++) wmem_s[i] = 32'd0;
    wmem_s[0] = 32'h3F000000; wmem_s[1] = 32'h3E800000; wmem_s[2] = 32'h00000000;
    wmem_s[3] = 32'hBF800000; wmem_s[4] = 32'hBF800000; wmem_s[5] = 32'h3F000000;
    for (int i = 0; i < 16; i++) amem_d[i] = i2f(i + 1);
    for (int i = 0; i < 128; i++) wmem_d[i] = 32'd0;

    rst_s = 1'b1; rst_d = 1'b1; start_s = 1'b0; start_d = 1'b0;
    out_ready_s = 1'b1; out_ready_d = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctrl_s", 64'({busy_s, done_s, out_valid_s, out_idx_s, act_addr_s, w_addr_s}), 64'd0);
    chk("rst_data_s", 64'(out_data_s | mul_x_s | mul_y_s | add_a_s | add_b_s), 64'd0);
    rst_s = 1'b0; rst_d = 1'b0;
    @(negedge clk);

    // run 1: out_ready high throughout
    sq_s.push_back(mk(0, 32'h3F800000, 4));
    sq_s.push_back(mk(1, n1, 8));
    start_pulse(1'b0);
    chk("busy_cyc1", 64'(busy_s), 64'd1);
    wait_done(1'b0, 9);

    // run 2: out_ready low for 5 cycles at node 0
    sq_s.push_back(mk(0, 32'h3F800000, 9));
    sq_s.push_back(mk(1, n1, 13));
    out_ready_s = 1'b0;
    start_pulse(1'b0);
    while (cyc - t0 < 9) @(negedge clk);
    out_ready_s = 1'b1;
    wait_done(1'b0, 14);

    // run 3: extra start pulse during MAC is ignored
    sq_s.push_back(mk(0, 32'h3F800000, 4));
    sq_s.push_back(mk(1, n1, 8));
    start_pulse(1'b0);
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(1'b0, 9);

    // default-size instance: reset mid-pass, then a full pass
    for (int n = 0; n < DM; n++) begin
      s = n - 4;
      wmem_d[n * 16 + DN] = i2f(n - 4);
      for (int i = 0; i < DN; i++) begin
        w = ((n + i) % 3) - 1;
        wmem_d[n * 16 + i] = i2f(w);
        s += (i + 1) * w;
      end
      sq_d.push_back(mk(n, act_f(s), 17 + 17 * n));
    end
    begin
      exp_t keep[$];
      keep = sq_d;
      sq_d.delete();
      start_pulse(1'b1);
      while (cyc - t0 < 3) @(negedge clk);
      rst_d = 1'b1;
      @(negedge clk);
      chk("midrst_ctrl_d", 64'({busy_d, done_d, out_valid_d, out_idx_d, act_addr_d, w_addr_d}), 64'd0);
      chk("midrst_data_d", 64'(out_data_d | mul_x_d | mul_y_d | add_a_d | add_b_d), 64'd0);
      rst_d = 1'b0;
      @(negedge clk);
      sq_d = keep;
    end
    start_pulse(1'b1);
    wait_done(1'b1, 137);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/node_mac_sched.md
# node_mac_sched

Time-multiplexed scheduler for one fully-connected neuron layer. Instead of one float_mult per input and a float_adder tree per node, one shared float_mult/float_adder pair is sequenced over every (node, input) pair of the layer. Weights and biases come from a synchronous weight memory and activations from a synchronous activation buffer. Each finished node result gets an optional ReLU and is handed downstream over a valid/ready port.

## Interface
- N_IN, 15: inputs per node.
- N_NODE, 8: nodes in the layer.
- WADDR_W, $clog2(N_NODE*(N_IN+1)): weight-memory address width.
- AADDR_W, max(1,$clog2(N_IN)): activation address width.
- NADDR_W, max(1,$clog2(N_NODE)): node-index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a layer pass when idle.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the last node is accepted downstream.
- act_addr  out  AADDR_W  activation read address; data returns next cycle.
- act_data  in  32  IEEE-754 single activation.
- w_addr  out  WADDR_W  weight/bias read address; data returns next cycle.
- w_data  in  32  IEEE-754 single weight or bias.
- mul_x, mul_y  out  32 each  operands to the shared combinational float_mult.
- mul_z  in  32  float_mult product.
- add_a, add_b  out  32 each  operands to the shared combinational float_adder.
- add_out  in  32  float_adder sum.
- out_valid  out  1  node result valid.
- out_ready  in  1  downstream accepts.
- out_idx  out  NADDR_W  node index of out_data.
- out_data  out  32  node result.

## Operation
- Memory layout: node n occupies words n*(N_IN+1) .. n*(N_IN+1)+N_IN-1 for weights, in input order. Its bias is at word n*(N_IN+1)+N_IN.
- IDLE: busy=0. An accepted start clears the node counter, drives the bias address, and moves to LOAD_B. start is ignored in every other state.
- LOAD_B: acc <= w_data (the bias). Drives act_addr=0 and w_addr=node base+0. Moves to MAC with i=0.
- MAC, at index i:
  - mul_x=act_data, mul_y=w_data, add_a=acc, add_b=mul_z.
  - acc <= add_out.
  - If i<N_IN-1: issue addresses for i+1 and increment i.
  - If i==N_IN-1: move to OUT.
- OUT:
  - Hold out_valid=1, out_idx=node, out_data=f(acc) until out_valid && out_ready.
  - On the handshake cycle: if node==N_NODE-1, go to DONE; otherwise increment node, drive the next bias address, and go to LOAD_B.
  - out_data and out_idx stay stable while out_valid is high.
- DONE: done=1 for one cycle, then IDLE.
- Operands driven outside MAC are 0.
- Accumulation order is fixed: bias first, then inputs 0..N_IN-1.
- f(acc) is set by the configuration macro below.
- Reset at any time, including mid-pass, forces IDLE. All outputs reset to 0: busy, done, out_valid, out_idx, out_data, act_addr, w_addr and all operand ports. A partial pass is discarded, with no result and no done.

## Timing
- Start-accept cycle is cycle 0.
- Node 0: LOAD_B at cycle 1, MAC at cycles 2..N_IN+1, first out_valid at cycle N_IN+2.
- Per node with out_ready held high: N_IN+2 cycles.
  - LOAD_B and MAC take N_IN+1 cycles.
  - OUT takes 1 cycle, with the next bias address driven in the same cycle.
- done is at cycle N_NODE*(N_IN+2)+1. For the defaults that is cycle 137.
- Every cycle of out_ready low in OUT adds exactly one cycle.
- Pipelining: the multiply and add for an element are combinational within a single MAC cycle, so there is one MAC per cycle with no bubbles.

## Configuration
- NODE_RELU_EN defined: out_data = acc[31] ? 32'd0 : acc. Negative results, including -0.0, output +0.0.
- NODE_RELU_EN undefined: out_data = acc unchanged, for a linear output layer.

## Structure
- Package node_sched_pkg holds:
  - the state enum (IDLE, LOAD_B, MAC, OUT, DONE);
  - FP_W=32;
  - FP_ZERO=32'h00000000.
- One sub-module, node_sched_addrgen, holds the node/index counters and the w_addr/act_addr generation (base = node*(N_IN+1)). The FSM and the accumulator stay in the top.
- float_mult and float_adder are instantiated beside this block, not inside it.

## Test plan
Bench setup for the first four scenarios: N_IN=2, N_NODE=2, real float_mult/float_adder attached, A=[0x3F800000, 0x40000000].

- Node 0 weights [0x3F000000, 0x3E800000], bias 0x00000000, out_ready=1: out_valid at cycle 4 with out_idx=0, out_data=0x3F800000 (1.0).
- Node 1 weights [0xBF800000, 0xBF800000], bias 0x3F000000 (sum -2.5):
  - with NODE_RELU_EN: out_idx=1, out_data=0x00000000 at cycle 8;
  - without NODE_RELU_EN: out_data=0xC0200000;
  - done at cycle 9.
- out_ready held low 5 cycles at node 0: out_valid, out_idx and out_data stay stable; done moves to cycle 14.
- start pulsed during MAC: ignored, and results and timing are identical to the first run.
- rst asserted at cycle 3 of a default-parameter pass: next edge shows all outputs 0 and IDLE. A new start gives a full correct pass with done at cycle 137.
